// File: rtl/palette_pkg.sv
// Shared definitions for the palette sequencer: the power-on palette and FSM states.
package palette_pkg;

    localparam int PAL_ROM_N = 16;

    // Power-on palette contents; entry i of a deeper palette repeats entry i % 16.
    localparam logic [15:0] DEFAULT_PALETTE [PAL_ROM_N] = '{
        16'hF801, 16'h07E0, 16'h001F, 16'hFFFF,
        16'hF000, 16'h0F00, 16'h00F0, 16'h000F,
        16'hFF00, 16'h0FF0, 16'h00FF, 16'hF00F,
        16'hF807, 16'hFC03, 16'hFE01, 16'hA5A5
    };

    typedef enum logic {
        SEQ_MANUAL,
        SEQ_AUTO
    } seq_state_t;

    function automatic logic [15:0] default_color(input int i);
        return DEFAULT_PALETTE[i % PAL_ROM_N];
    endfunction

endpackage

// File: rtl/palette_sequencer_btn_debounce.sv
// Button conditioner: two-flop synchroniser, run-length debounce, rising-edge pulse.
module btn_debounce
    import palette_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_rise
);

    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync_1;
    logic             sync_2;
    logic             level;
    logic [CNT_W-1:0] cnt;
    logic             flip;

    // The level flips on the DEBOUNCE_CYC-th consecutive sample that disagrees with it.
    assign flip = (sync_2 != level) && (cnt == CNT_LAST);

    // Bring the raw pin into the clk domain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= btn_raw;
            sync_2 <= sync_1;
        end
    end

    // Count disagreeing samples; any agreeing sample restarts the run.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync_2 == level) begin
            cnt <= '0;
        end else if (flip) begin
            cnt   <= '0;
            level <= sync_2;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // One-cycle event on the debounced press only; release produces nothing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_rise <= 1'b0;
        end else begin
            btn_rise <= flip && sync_2;
        end
    end

endmodule

// File: rtl/palette_sequencer.sv
// Colour-palette sequencer: debounced next/prev, timed auto-advance, writable palette,
// registered colour output with a reload pulse for the fill engine.
//
// state      | meaning
// SEQ_MANUAL | steps only on button events, timer parked at its reload value
// SEQ_AUTO   | timer runs, terminal count issues a forward step
module palette_sequencer
    import palette_pkg::*;
#(
    parameter int  COLOR_W      = 16,
    parameter int  DEPTH        = 16,
    parameter int  DEBOUNCE_CYC = 4,
    parameter int  AUTO_PERIOD  = 1024,
    localparam int IDX_W        = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_next,
    input  logic               btn_prev,
    input  logic               auto_en,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_addr,
    input  logic [COLOR_W-1:0] wr_data,
    output logic [COLOR_W-1:0] color_out,
    output logic [IDX_W-1:0]   index_out,
    output logic               color_valid,
    output logic               wrap
);

    localparam int               TMR_W    = $clog2(AUTO_PERIOD);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(AUTO_PERIOD - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);

    seq_state_t         state_q;
    seq_state_t         state_d;
    logic               ev_next;
    logic               ev_prev;
    logic               tick;
    logic               manual_ev;
    logic               step_fwd;
    logic               step_bwd;
    logic               wr_ok;
    logic [IDX_W-1:0]   idx_new;
    logic               wrap_new;
    logic [COLOR_W-1:0] color_d;
    logic               valid_d;
    logic [TMR_W-1:0]   timer;
    logic [COLOR_W-1:0] pal [DEPTH];

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_dbn_next (
        .clk      (clk),
        .reset    (reset),
        .btn_raw  (btn_next),
        .btn_rise (ev_next)
    );

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_dbn_prev (
        .clk      (clk),
        .reset    (reset),
        .btn_raw  (btn_prev),
        .btn_rise (ev_prev)
    );

    assign wr_ok = wr_en && (int'(wr_addr) < DEPTH);

    // Mode register follows auto_en one cycle late.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= SEQ_MANUAL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next mode, step resolution and the colour that the next edge will present.
    always_comb begin
        state_d   = auto_en ? SEQ_AUTO : SEQ_MANUAL;
        tick      = (state_q == SEQ_AUTO) && (timer == '0);
        manual_ev = ev_next || ev_prev;
        // Simultaneous next and prev cancel; prev wins over a timer tick.
        step_bwd  = ev_prev && !ev_next;
        step_fwd  = !ev_prev && (ev_next || tick);
        idx_new   = index_out;
        wrap_new  = 1'b0;
        color_d   = color_out;
        valid_d   = 1'b0;

        if (step_fwd) begin
            if (index_out == IDX_LAST) begin
                idx_new  = '0;
                wrap_new = 1'b1;
            end else begin
                idx_new = index_out + IDX_W'(1);
            end
        end else if (step_bwd) begin
            if (index_out == '0) begin
                idx_new  = IDX_LAST;
                wrap_new = 1'b1;
            end else begin
                idx_new = index_out - IDX_W'(1);
            end
        end

        // A write landing on the entry about to be shown goes straight through.
        if (step_fwd || step_bwd) begin
            color_d = (wr_ok && (wr_addr == idx_new)) ? wr_data : pal[idx_new];
            valid_d = 1'b1;
        end else if (wr_ok && (wr_addr == index_out)) begin
            color_d = wr_data;
            valid_d = 1'b1;
        end
    end

    // Auto-advance down-counter; parked in manual mode and restarted by any button event.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer <= TMR_LOAD;
        end else if ((state_q == SEQ_MANUAL) || manual_ev || tick) begin
            timer <= TMR_LOAD;
        end else begin
            timer <= timer - TMR_W'(1);
        end
    end

    // Palette storage; out-of-range writes are dropped by wr_ok.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pal[i] <= COLOR_W'(default_color(i));
            end
        end else if (wr_ok) begin
            pal[wr_addr] <= wr_data;
        end
    end

    // Registered index, colour and the two one-cycle pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            index_out   <= '0;
            color_out   <= COLOR_W'(default_color(0));
            color_valid <= 1'b0;
            wrap        <= 1'b0;
        end else begin
            index_out   <= idx_new;
            color_out   <= color_d;
            color_valid <= valid_d;
            wrap        <= wrap_new;
        end
    end

endmodule
